// File: rtl/count_checker_if.sv
// count_checker_if: counter-under-check taps and checker result bus.
interface count_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERRW = 8
);
  logic EN;
  logic load;
  logic [WIDTH-1:0] CNT_In;
  logic [WIDTH-1:0] CNT;
  logic chk_en;
  logic err;
  logic err_sticky;
  logic [ERRW-1:0] err_cnt;
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_got;
  logic wrap;
  logic [WIDTH-1:0] exp_cnt;
  modport master(
    output EN, load, CNT_In, CNT, chk_en,
    input err, err_sticky, err_cnt, first_exp, first_got, wrap, exp_cnt
  );
  modport slave(
    input EN, load, CNT_In, CNT, chk_en,
    output err, err_sticky, err_cnt, first_exp, first_got, wrap, exp_cnt
  );
endinterface

// File: rtl/count_checker.sv
// count_checker: shadows a load/enable counter and flags, counts and captures mismatches.
module count_checker #(
  parameter int WIDTH = 8,
  parameter int ERRW = 8,
  parameter int RESYNC = 1
) (
  input logic clk,
  input logic res,
  count_checker_if.slave bus
);
  logic mismatch;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] next;
  assign mismatch = bus.chk_en && (bus.CNT != bus.exp_cnt);
  // realigning lets a single glitch count once instead of every following cycle
  assign base = (RESYNC != 0 && mismatch) ? bus.CNT : bus.exp_cnt;
  assign next = bus.load ? bus.CNT_In : bus.EN ? base + 1'b1 : base;
  always_ff @(posedge clk) begin
    if (res) begin
      bus.exp_cnt <= '0;
      bus.err <= 1'b0;
      bus.err_sticky <= 1'b0;
      bus.err_cnt <= '0;
      bus.first_exp <= '0;
      bus.first_got <= '0;
      bus.wrap <= 1'b0;
    end else begin
      bus.exp_cnt <= next;
      bus.err <= mismatch;
      bus.wrap <= !bus.load && bus.EN && (&base);
      if (mismatch && !(&bus.err_cnt)) bus.err_cnt <= bus.err_cnt + 1'b1;
      if (mismatch && !bus.err_sticky) begin
        bus.err_sticky <= 1'b1;
        bus.first_exp <= bus.exp_cnt;
        bus.first_got <= bus.CNT;
      end
    end
  end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: random and directed checks of both RESYNC flavours against a behavioural model.
module tb_count_checker;
  logic clk = 1'b0;
  logic res, en, load, chk_en;
  logic [7:0] cnt_in, cnt;
  int checks = 0;
  int passed = 0;
  typedef struct {
    int exp_v, err, sticky, ecnt, fexp, fgot, wrap;
  } mstate_t;
  mstate_t m[2];

  always #5 clk = ~clk;

  count_checker_if #(.WIDTH(8), .ERRW(8)) b0 ();
  count_checker_if #(.WIDTH(8), .ERRW(8)) b1 ();
  assign b0.EN = en;
  assign b0.load = load;
  assign b0.CNT_In = cnt_in;
  assign b0.CNT = cnt;
  assign b0.chk_en = chk_en;
  assign b1.EN = en;
  assign b1.load = load;
  assign b1.CNT_In = cnt_in;
  assign b1.CNT = cnt;
  assign b1.chk_en = chk_en;

  count_checker #(.WIDTH(8), .ERRW(8), .RESYNC(0)) dut0 (.clk(clk), .res(res), .bus(b0));
  count_checker #(.WIDTH(8), .ERRW(8), .RESYNC(1)) dut1 (.clk(clk), .res(res), .bus(b1));

  task automatic check(input string tag, input int got, input int exp_v);
    checks++;
    if (got === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
  endtask

  // Spec-level model: index 0 never realigns, index 1 realigns on mismatch.
  task automatic model_edge();
    for (int r = 0; r < 2; r++) begin
      if (res) m[r] = '{default: 0};
      else begin
        int mis, base;
        mis = (chk_en && int'(cnt) != m[r].exp_v) ? 1 : 0;
        base = (r == 1 && mis == 1) ? int'(cnt) : m[r].exp_v;
        m[r].wrap = (!load && en && base == 255) ? 1 : 0;
        if (mis == 1) begin
          m[r].ecnt = (m[r].ecnt < 255) ? m[r].ecnt + 1 : 255;
          if (m[r].sticky == 0) begin
            m[r].fexp = m[r].exp_v;
            m[r].fgot = int'(cnt);
            m[r].sticky = 1;
          end
        end
        m[r].err = mis;
        m[r].exp_v = load ? int'(cnt_in) : en ? (base + 1) % 256 : base;
      end
    end
  endtask

  task automatic compare_all();
    check("r0_exp_cnt", int'(b0.exp_cnt), m[0].exp_v);
    check("r0_err", int'(b0.err), m[0].err);
    check("r0_sticky", int'(b0.err_sticky), m[0].sticky);
    check("r0_err_cnt", int'(b0.err_cnt), m[0].ecnt);
    check("r0_first_exp", int'(b0.first_exp), m[0].fexp);
    check("r0_first_got", int'(b0.first_got), m[0].fgot);
    check("r0_wrap", int'(b0.wrap), m[0].wrap);
    check("r1_exp_cnt", int'(b1.exp_cnt), m[1].exp_v);
    check("r1_err", int'(b1.err), m[1].err);
    check("r1_sticky", int'(b1.err_sticky), m[1].sticky);
    check("r1_err_cnt", int'(b1.err_cnt), m[1].ecnt);
    check("r1_first_exp", int'(b1.first_exp), m[1].fexp);
    check("r1_first_got", int'(b1.first_got), m[1].fgot);
    check("r1_wrap", int'(b1.wrap), m[1].wrap);
  endtask

  task automatic step(input logic r_, input logic e_, input logic l_, input int ci, input int c, input logic k);
    res = r_;
    en = e_;
    load = l_;
    cnt_in = ci[7:0];
    cnt = c[7:0];
    chk_en = k;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    check("reset_exp", int'(b1.exp_cnt), 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, i, 1);
    check("count_clean", int'(b1.err_cnt), 0);
    check("count_track", int'(b1.exp_cnt), 20);
    step(0, 0, 1, 'h11, m[1].exp_v, 1);
    step(0, 1, 0, 0, 'h11, 1);
    step(0, 0, 0, 0, 'h12, 1);
    step(0, 1, 1, 'h11, 'h12, 1);
    check("load_beats_en", int'(b1.exp_cnt), 'h11);
    check("load_no_err", int'(b1.err_cnt), 0);
    step(0, 0, 1, 'h14, 'h11, 1);
    step(0, 0, 0, 0, 'h14, 1);
    step(0, 0, 0, 0, 'h15, 1);
    check("mis_err", int'(b1.err), 1);
    check("mis_cnt", int'(b1.err_cnt), 1);
    check("mis_fexp", int'(b1.first_exp), 'h14);
    check("mis_fgot", int'(b1.first_got), 'h15);
    check("mis_sticky", int'(b1.err_sticky), 1);
    step(0, 0, 0, 0, 'h15, 1);
    check("err_one_cycle", int'(b1.err), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 'h40 + i, 1);
    check("five_errs", int'(b1.err_cnt), 5);
    check("first_kept", int'(b1.first_got), 'h15);
    step(1, 0, 0, 0, 'h99, 1);
    check("rst_cnt", int'(b1.err_cnt), 0);
    check("rst_sticky", int'(b1.err_sticky), 0);
    check("rst_err0", int'(b0.err), 0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_no_pulse", int'(b1.err), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 'h77, 0);
    check("chk_off_cnt", int'(b1.err_cnt), 0);
    check("chk_off_cnt0", int'(b0.err_cnt), 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 'hFE, 0, 1);
    step(0, 1, 0, 0, 'hFE, 1);
    step(0, 1, 0, 0, 'hFF, 1);
    check("wrap_pulse", int'(b1.wrap), 1);
    check("wrap_exp", int'(b1.exp_cnt), 0);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_once", int'(b1.wrap), 0);
    check("wrap_no_err", int'(b1.err_cnt), 0);
    step(0, 0, 1, 'hFF, 0, 1);
    step(0, 1, 1, 0, 'hFF, 1);
    check("load_no_wrap", int'(b1.wrap), 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 'h1F, 0, 1);
    step(0, 1, 0, 0, 'h1F, 1);
    step(0, 1, 0, 0, 'h20, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 'h30 + i, 1);
    check("jump_resync", int'(b1.err_cnt), 1);
    check("jump_noresync", int'(b0.err_cnt), 4);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, (i % 2 == 1) ? 'h55 : 'hAA, 1);
    check("sat_r1", int'(b1.err_cnt), 'hFF);
    check("sat_r0", int'(b0.err_cnt), 'hFF);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      logic rr, ee, ll, kk;
      int cc;
      rr = ($urandom % 40) == 0;
      ee = $urandom % 2 == 1;
      ll = ($urandom % 8) == 0;
      kk = ($urandom % 4) != 0;
      cc = ($urandom % 6 == 0) ? int'($urandom % 256) : m[1].exp_v;
      step(rr, ee, ll, int'($urandom % 256), cc, kk);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
